// File: rtl/mem_bus_arbiter_pkg.sv
// Shared encodings for the I/D memory bus arbiter: burst codes, FSM states,
// master indices and the request bundle muxed onto the memory port.
package mem_bus_arbiter_pkg;

  localparam logic [1:0] BURST_NORMAL = 2'b00;
  localparam logic [1:0] BURST_INCR   = 2'b01;
  localparam logic [1:0] BURST_WRAP   = 2'b10;
  localparam logic [1:0] BURST_RSVD   = 2'b11;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_OWN_I = 3'd1;
  localparam logic [2:0] ST_OWN_D = 3'd2;
  localparam logic [2:0] ST_ERR_I = 3'd3;
  localparam logic [2:0] ST_ERR_D = 3'd4;

  localparam int M_I = 0;
  localparam int M_D = 1;

  typedef struct packed {
    logic        req;
    logic        wrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  burst;
    logic [3:0]  bstrobe;
  } mst_req_t;

  // Reserved encoding is treated as a single beat.
  function automatic logic is_burst(input logic [1:0] b);
    return (b == BURST_INCR) || (b == BURST_WRAP);
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_pick.sv
// Combinational two-request picker: single requester wins, then a forced
// (starved) requester, then fixed D priority or round-robin against rr_last.
module arb_pick2
  import mem_bus_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic [1:0] force_win,
  input  logic       mode,
  input  logic       rr_last,
  output logic [1:0] win
);

  always_comb begin
    win = 2'b00;
    if (req == 2'b01)      win = 2'b01;
    else if (req == 2'b10) win = 2'b10;
    else if (req == 2'b11) begin
      if (force_win == 2'b01)      win = 2'b01;
      else if (force_win == 2'b10) win = 2'b10;
      else if (mode && (rr_last == 1'(M_D))) win = 2'b01;
      else                         win = 2'b10;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master (I/D) arbiter for the unified memory port with burst lock,
// starvation bound and a memory-free error response for MPU-denied accesses.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int ARB_MODE    = 0,
  parameter int BURST_BEATS = 4,
  parameter int MAX_WAIT    = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic        i_wrb,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  input  logic [1:0]  i_burst,
  input  logic [3:0]  i_bstrobe,
  input  logic        i_deny,
  output logic [31:0] i_rdata,
  output logic        i_ack,
  output logic        i_stall,
  output logic        i_err,
  input  logic        d_req,
  input  logic        d_wrb,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [1:0]  d_burst,
  input  logic [3:0]  d_bstrobe,
  input  logic        d_deny,
  output logic [31:0] d_rdata,
  output logic        d_ack,
  output logic        d_stall,
  output logic        d_err,
  output logic        mem_req,
  output logic        mem_wrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [1:0]  mem_burst,
  output logic [3:0]  mem_bstrobe,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  input  logic        mem_stall,
  output logic [1:0]  grant
);

  localparam int BW = $clog2(BURST_BEATS + 1);
  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam logic [BW-1:0] BEATS_B  = BW'(BURST_BEATS);
  localparam logic [WW-1:0] WAIT_MAX = WW'(MAX_WAIT);

  logic [2:0]    state_q, state_d;
  logic [BW-1:0] beat_cnt_q, beat_cnt_d;
  logic [WW-1:0] wait_i_q, wait_i_d;
  logic [WW-1:0] wait_d_q, wait_d_d;
  logic          rr_last_q, rr_last_d;

  mst_req_t      ireq, dreq, own;
  logic          own_d, owning;
  logic [BW-1:0] beats_needed;
  logic          beat_acc, last_beat;
  logic [1:0]    win;

  assign ireq = '{req: i_req, wrb: i_wrb, addr: i_addr, wdata: i_wdata,
                  burst: i_burst, bstrobe: i_bstrobe};
  assign dreq = '{req: d_req, wrb: d_wrb, addr: d_addr, wdata: d_wdata,
                  burst: d_burst, bstrobe: d_bstrobe};

  assign own_d        = (state_q == ST_OWN_D);
  assign owning       = (state_q == ST_OWN_I) || own_d;
  assign own          = own_d ? dreq : ireq;
  assign beats_needed = is_burst(own.burst) ? BEATS_B : BW'(1);
  assign beat_acc     = mem_ack && !mem_stall;
  assign last_beat    = beat_acc && (beat_cnt_q == beats_needed - BW'(1));

  arb_pick2 u_pick (
    .req       ({d_req, i_req}),
    .force_win ({wait_d_q == WAIT_MAX, wait_i_q == WAIT_MAX}),
    .mode      (ARB_MODE != 0),
    .rr_last   (rr_last_q),
    .win       (win)
  );

  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    wait_i_d   = wait_i_q;
    wait_d_d   = wait_d_q;
    rr_last_d  = rr_last_q;
    case (state_q)
      ST_IDLE: begin
        if (win[M_D]) begin
          state_d   = d_deny ? ST_ERR_D : ST_OWN_D;
          rr_last_d = 1'(M_D);
          wait_d_d  = '0;
          if (i_req && (wait_i_q != WAIT_MAX)) wait_i_d = wait_i_q + WW'(1);
        end else if (win[M_I]) begin
          state_d   = i_deny ? ST_ERR_I : ST_OWN_I;
          rr_last_d = 1'(M_I);
          wait_i_d  = '0;
          if (d_req && (wait_d_q != WAIT_MAX)) wait_d_d = wait_d_q + WW'(1);
        end
      end
      ST_OWN_I, ST_OWN_D: begin
        // Dropping req mid-burst aborts; memory sees mem_req fall this cycle.
        if (!own.req || last_beat) begin
          state_d    = ST_IDLE;
          beat_cnt_d = '0;
        end else if (beat_acc) begin
          beat_cnt_d = beat_cnt_q + BW'(1);
        end
      end
      default: begin
        state_d    = ST_IDLE;
        beat_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      beat_cnt_q <= '0;
      wait_i_q   <= '0;
      wait_d_q   <= '0;
      rr_last_q  <= 1'(M_I);
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      wait_i_q   <= wait_i_d;
      wait_d_q   <= wait_d_d;
      rr_last_q  <= rr_last_d;
    end
  end

  // Outputs are forced low while rst is high, even with requests held.
  always_comb begin
    mem_req = 1'b0; mem_wrb = 1'b0; mem_addr = '0; mem_wdata = '0;
    mem_burst = '0; mem_bstrobe = '0;
    i_rdata = '0; i_ack = 1'b0; i_stall = 1'b0; i_err = 1'b0;
    d_rdata = '0; d_ack = 1'b0; d_stall = 1'b0; d_err = 1'b0;
    grant   = 2'b00;
    if (!rst) begin
      i_stall = i_req;
      d_stall = d_req;
      if (owning) begin
        mem_req     = own.req;
        mem_wrb     = own.wrb;
        mem_addr    = own.addr;
        mem_wdata   = own.wdata;
        mem_burst   = own.burst;
        mem_bstrobe = own.bstrobe;
        grant       = own_d ? 2'b10 : 2'b01;
        if (own_d) begin
          d_rdata = mem_rdata; d_ack = mem_ack; d_stall = mem_stall;
        end else begin
          i_rdata = mem_rdata; i_ack = mem_ack; i_stall = mem_stall;
        end
      end else if (state_q == ST_ERR_I) begin
        i_ack = 1'b1; i_err = 1'b1; i_stall = 1'b0;
      end else if (state_q == ST_ERR_D) begin
        d_ack = 1'b1; d_err = 1'b1; d_stall = 1'b0;
      end
    end
  end

endmodule
